// File: rtl/phs_snap_ctrl.sv
// Phase-snapshot capture controller: packs 32-bit phase samples into 64-bit BRAM words.
// Optional trigger timestamp is enabled by defining PHS_SNAP_TIMESTAMP_EN.
module phs_snap_ctrl #(
  parameter int ADDR_W = 9,
  parameter int IN_W   = 32,
  parameter int TS_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ctrl_arm,
  input  logic                ctrl_abort,
  input  logic                ctrl_trig_sw,
  input  logic                trig_ext,
  input  logic [ADDR_W:0]     cap_len,
  input  logic [IN_W-1:0]     in_data,
  input  logic                in_valid,
  output logic                bram_we,
  output logic                bram_en_a,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [2*IN_W-1:0]   bram_wr_data,
  output logic                snap_busy,
  output logic                snap_done,
  output logic [ADDR_W:0]     words_written,
  output logic [TS_W-1:0]     trig_ts
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic              r_phase;
  logic              r_arm_d;
  logic              r_trig_d;
  logic [IN_W-1:0]   r_lo;
  logic [ADDR_W:0]   r_len;

  logic              w_arm_rise;
  logic              w_trig_rise;
  logic [ADDR_W:0]   w_len;
  logic [ADDR_W:0]   w_words_inc;

  assign w_arm_rise  = ctrl_arm & ~r_arm_d;
  assign w_trig_rise = ctrl_trig_sw & ~r_trig_d;
  assign w_words_inc = words_written + ONE_WORD;
  // Zero or oversize lengths mean "fill the whole buffer"
  assign w_len       = ((cap_len == '0) || (cap_len > FULL_LEN)) ? FULL_LEN : cap_len;
  assign bram_en_a   = bram_we;

`ifdef PHS_SNAP_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + {{(TS_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign trig_ts = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_phase       <= 1'b0;
      r_arm_d       <= 1'b0;
      r_trig_d      <= 1'b0;
      r_lo          <= '0;
      r_len         <= '0;
      bram_we       <= 1'b0;
      bram_addr     <= '0;
      bram_wr_data  <= '0;
      snap_busy     <= 1'b0;
      snap_done     <= 1'b0;
      words_written <= '0;
`ifdef PHS_SNAP_TIMESTAMP_EN
      trig_ts       <= '0;
`endif
    end else begin
      r_arm_d  <= ctrl_arm;
      r_trig_d <= ctrl_trig_sw;
      bram_we  <= 1'b0;
      // Abort wins over everything; words_written is left for software to inspect
      if (ctrl_abort) begin
        r_state   <= S_IDLE;
        r_phase   <= 1'b0;
        snap_busy <= 1'b0;
        snap_done <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_arm_rise) begin
              r_state       <= S_ARMED;
              r_phase       <= 1'b0;
              snap_busy     <= 1'b1;
              snap_done     <= 1'b0;
              words_written <= '0;
              bram_addr     <= '0;
            end
          end
          S_ARMED: begin
            if (w_trig_rise || trig_ext) begin
              r_state <= S_CAPTURE;
              r_len   <= w_len;
`ifdef PHS_SNAP_TIMESTAMP_EN
              trig_ts <= r_ts_cnt;
`endif
            end
          end
          S_CAPTURE: begin
            if (in_valid) begin
              if (!r_phase) begin
                r_lo    <= in_data;
                r_phase <= 1'b1;
              end else begin
                r_phase       <= 1'b0;
                bram_we       <= 1'b1;
                bram_addr     <= words_written[ADDR_W-1:0];
                bram_wr_data  <= {in_data, r_lo};
                words_written <= w_words_inc;
                if (w_words_inc == r_len) begin
                  r_state   <= S_DONE;
                  snap_busy <= 1'b0;
                  snap_done <= 1'b1;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phs_snap_ctrl.sv
// Randomised scoreboard bench for phs_snap_ctrl; expected writes come from a sample-list
// reference model and are popped by an independent monitor whenever bram_we is seen.
module tb_phs_snap_ctrl;

  localparam int ADDR_W = 9;
  localparam int IN_W   = 32;
  localparam int TS_W   = 32;
  localparam int FULL   = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                ctrl_arm = 1'b0;
  logic                ctrl_abort = 1'b0;
  logic                ctrl_trig_sw = 1'b0;
  logic                trig_ext = 1'b0;
  logic [ADDR_W:0]     cap_len = '0;
  logic [IN_W-1:0]     in_data = '0;
  logic                in_valid = 1'b0;
  logic                bram_we;
  logic                bram_en_a;
  logic [ADDR_W-1:0]   bram_addr;
  logic [2*IN_W-1:0]   bram_wr_data;
  logic                snap_busy;
  logic                snap_done;
  logic [ADDR_W:0]     words_written;
  logic [TS_W-1:0]     trig_ts;

  always #5 clk = ~clk;

  phs_snap_ctrl #(.ADDR_W(ADDR_W), .IN_W(IN_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_arm(ctrl_arm), .ctrl_abort(ctrl_abort),
    .ctrl_trig_sw(ctrl_trig_sw), .trig_ext(trig_ext), .cap_len(cap_len),
    .in_data(in_data), .in_valid(in_valid), .bram_we(bram_we), .bram_en_a(bram_en_a),
    .bram_addr(bram_addr), .bram_wr_data(bram_wr_data), .snap_busy(snap_busy),
    .snap_done(snap_done), .words_written(words_written), .trig_ts(trig_ts)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [2*IN_W-1:0] data;
    logic              last;
  } wr_t;

  typedef enum {M_IDLE, M_ARMED, M_CAPT, M_DONE} mode_t;

  wr_t          expQ[$];
  logic [31:0]  mPend[$];
  mode_t        mode = M_IDLE;
  int           mWords = 0;
  int           mTarget = FULL;
  logic         mArmPrev = 1'b0;
  logic         mTrigPrev = 1'b0;
  longint       tsModel = 0;
  longint       cyc = 0;
  int           total = 0;
  int           bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkTs();
`ifdef PHS_SNAP_TIMESTAMP_EN
    longint diff;
    total++;
    diff = longint'(trig_ts) - tsModel;
    if ($isunknown(trig_ts) || diff > 1 || diff < -1) begin
      bad++;
      $display("[TB] FAIL trig_ts: got %0d, expected %0d +-1", trig_ts, tsModel);
    end
`else
    checkOutput("trig_ts", trig_ts, 64'(tsModel));
`endif
  endtask

  // Compare the status outputs with the abstract model after the last edge
  task automatic checkModel(input string tag);
    $display("[TB] check point: %s", tag);
    checkOutput("snap_busy", snap_busy, (mode == M_ARMED || mode == M_CAPT));
    checkOutput("snap_done", snap_done, (mode == M_DONE));
    checkOutput("words_written", words_written, 64'(mWords));
    checkTs();
  endtask

  task automatic checkAllZero();
    checkOutput("rst_bram_we", bram_we, 0);
    checkOutput("rst_bram_en_a", bram_en_a, 0);
    checkOutput("rst_bram_addr", bram_addr, 0);
    checkOutput("rst_bram_wr_data", bram_wr_data, 0);
    checkOutput("rst_snap_busy", snap_busy, 0);
    checkOutput("rst_snap_done", snap_done, 0);
    checkOutput("rst_words_written", words_written, 0);
    checkOutput("rst_trig_ts", trig_ts, 0);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the
  // reference model for the coming rising edge, then wait for the next falling edge.
  task automatic applyStimulus(input logic arm, input logic trigSw, input logic ext,
                               input logic abort, input logic valid, input logic [31:0] data);
    logic armRise;
    logic trigRise;
    wr_t  w;
    ctrl_arm     = arm;
    ctrl_trig_sw = trigSw;
    trig_ext     = ext;
    ctrl_abort   = abort;
    in_valid     = valid;
    in_data      = data;
    armRise  = arm && !mArmPrev;
    trigRise = trigSw && !mTrigPrev;
    if (abort) begin
      mode = M_IDLE;
      mPend.delete();
    end else begin
      case (mode)
        M_IDLE, M_DONE: begin
          if (armRise) begin
            mode   = M_ARMED;
            mWords = 0;
            mPend.delete();
          end
        end
        M_ARMED: begin
          if (trigRise || ext) begin
            mode    = M_CAPT;
            mTarget = (cap_len == 0 || int'(cap_len) > FULL) ? FULL : int'(cap_len);
`ifdef PHS_SNAP_TIMESTAMP_EN
            tsModel = cyc;
`else
            tsModel = 0;
`endif
          end
        end
        M_CAPT: begin
          if (valid) begin
            mPend.push_back(data);
            if (mPend.size() == 2) begin
              w.addr = ADDR_W'(mWords);
              w.data = {mPend[1], mPend[0]};
              mWords++;
              w.last = (mWords == mTarget);
              expQ.push_back(w);
              mPend.delete();
              if (w.last) mode = M_DONE;
            end
          end
        end
        default: mode = M_IDLE;
      endcase
    end
    mArmPrev  = arm;
    mTrigPrev = trigSw;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic doReset();
    ctrl_arm = 0; ctrl_trig_sw = 0; trig_ext = 0; ctrl_abort = 0; in_valid = 0;
    #2 rst_n = 1'b0;
    #1 checkAllZero();
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    mode      = M_IDLE;
    mWords    = 0;
    mPend.delete();
    mArmPrev  = 1'b0;
    mTrigPrev = 1'b0;
    tsModel   = 0;
    cyc       = 0;
  endtask

  // Monitor: every port-A write must match the head of the expected queue
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (bram_we === 1'b1 || bram_en_a === 1'b1) begin
      checkOutput("en_eq_we", bram_en_a, bram_we);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write", bram_addr, bram_wr_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", bram_addr, e.addr);
        checkOutput("wr_data", bram_wr_data, e.data);
        checkOutput("wr_words", words_written, 64'(e.addr) + 1);
        checkOutput("wr_done", snap_done, e.last);
        checkOutput("wr_busy", snap_busy, !e.last);
      end
    end
  end

  initial begin
    int len;
    int guard;
    @(negedge clk);
    doReset();

    // Triggers in IDLE do nothing; trigger coincident with arm is ignored
    idle(90);
    applyStimulus(0, 1, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkModel("trigger_in_idle");
    cap_len = '0;
    applyStimulus(1, 1, 1, 0, 1, 32'hDEAD);
    checkModel("arm_with_trigger");
    applyStimulus(0, 1, 0, 0, 1, 32'hBEEF);
    applyStimulus(0, 0, 0, 0, 1, 32'hCAFE);
    checkModel("still_armed");

    // Software trigger, cap_len=0 -> full 512-word capture of a 0..1023 ramp
    applyStimulus(0, 1, 0, 0, 1, 32'hBAD0);
    for (int i = 0; i < 2 * FULL; i++) applyStimulus(0, 0, 0, 0, 1, 32'(i));
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 32'(5000 + i));
    checkModel("full_capture");

    // Re-arm from DONE, length 3, samples on alternate cycles
    cap_len = 10'd3;
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkModel("rearm_from_done");
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, (i % 2) == 0, $urandom);
    checkModel("short_gapped");

    // Randomised lengths, gaps and trigger sources
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 24);
      cap_len = 10'(len);
      applyStimulus(1, 0, 0, 0, 0, 32'h0);
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) applyStimulus(0, 1, 0, 0, 1, $urandom);
      else applyStimulus(0, 0, 1, 0, 1, $urandom);
      guard = 0;
      while (mode == M_CAPT && guard < 400) begin
        applyStimulus(0, 0, 0, 0, ($urandom_range(0, 2) != 0), $urandom);
        guard++;
      end
      idle(3);
      checkModel("random_run");
    end

    // Abort after 5 words
    cap_len = 10'd20;
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, $urandom);
    applyStimulus(0, 0, 0, 1, 1, $urandom);
    checkModel("abort");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, (i == 2), 0, 1, $urandom);
    checkModel("after_abort");
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkModel("rearm_after_abort");

    // Asynchronous reset in the middle of a capture
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, $urandom);
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(0, (i == 3), (i == 5), 0, 1, $urandom);
    checkModel("after_reset");

    // Oversize length behaves as a full capture
    cap_len = 10'd700;
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 2 * FULL + 2; i++) applyStimulus(0, 0, 0, 0, 1, $urandom);
    checkModel("oversize_len");

    idle(3);
    checkOutput("pending_writes", 64'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
